// File: rtl/spi_txn_sequencer_pkg.sv
// Shared definitions for the SPI slave transaction sequencer.
// Contents:
//   ADDR_BITS_DEF / DATA_BITS_DEF : default frame field widths
//   READ                          : value of the R/W bit that selects a read
//   state_e                       : sequencer state encoding
package spi_pkg;

    localparam int ADDR_BITS_DEF = 7;
    localparam int DATA_BITS_DEF = 8;

    localparam logic READ = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        GET,
        GOT,
        READ_WAIT,
        LOAD,
        SEND,
        WRITE_RX,
        WRITE_MEM,
        DONE
    } state_e;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Handshake bundle between the sequencer and the SPI slave datapath.
// Signals:
//   cs_n, sclk_pos, sclk_neg, sr_lsb             : conditioned SPI inputs (to sequencer)
//   addr_we, dm_we, sr_we, miso_buf_en, busy, abort : sequencer controls (from sequencer)
// Modports:
//   slave  : the sequencer side
//   master : the side that drives SPI events and consumes the controls
interface spi_txn_sequencer_if;

    logic cs_n;
    logic sclk_pos;
    logic sclk_neg;
    logic sr_lsb;
    logic addr_we;
    logic dm_we;
    logic sr_we;
    logic miso_buf_en;
    logic busy;
    logic abort;

    modport slave (
        input  cs_n, sclk_pos, sclk_neg, sr_lsb,
        output addr_we, dm_we, sr_we, miso_buf_en, busy, abort
    );

    modport master (
        output cs_n, sclk_pos, sclk_neg, sr_lsb,
        input  addr_we, dm_we, sr_we, miso_buf_en, busy, abort
    );

endinterface

// File: rtl/spi_txn_sequencer_bit_counter.sv
// Bit counter for the sequencer's address and data phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one bit
//   count      : current count
module spi_bit_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holds at all-ones rather than wrapping; the sequencer leaves each
    // counting state well before that, so this only guards misuse.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spi_txn_sequencer.sv
// Single-clock transaction sequencer for the SPI slave memory datapath.
// One frame per chip-select window: ADDR_BITS address bits, one R/W bit,
// then DATA_BITS data bits (driven out on a read, captured on a write).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport; cs_n/sclk_pos/sclk_neg/sr_lsb in,
//           addr_we/dm_we/sr_we/miso_buf_en/busy/abort out (all registered)
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_W     = $clog2(ADDR_BITS + DATA_BITS + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_txn_sequencer_if.slave   bus
);

    // Count values held just before the terminal edge of each phase.
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    state_e           state_q, state_d;
    logic             rw_q, rw_d;
    logic             abort_d;
    logic             cnt_clr, cnt_inc;
    logic             data_edge;
    logic [CNT_W-1:0] cnt;

    logic addr_we_q, dm_we_q, sr_we_q, miso_buf_en_q, busy_q, abort_q;

    spi_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt)
    );

    // Readout bits advance on sclk falling edges, received bits on rising.
    assign data_edge = (rw_q == READ) ? bus.sclk_neg : bus.sclk_pos;

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        abort_d = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.cs_n) state_d = GET;
            end
            GET: begin
                cnt_inc = bus.sclk_pos;
                // The transition fires on the terminal edge itself so the
                // read path reaches SEND before the first readout sclk_neg.
                if (bus.sclk_pos && (cnt == ADDR_LAST)) state_d = GOT;
            end
            GOT: begin
                rw_d    = bus.sr_lsb;
                state_d = (bus.sr_lsb == READ) ? READ_WAIT : WRITE_RX;
            end
            READ_WAIT: state_d = LOAD;
            LOAD:      state_d = SEND;
            SEND, WRITE_RX: begin
                cnt_inc = data_edge;
                if (data_edge && (cnt == DATA_LAST)) begin
                    state_d = (state_q == SEND) ? DONE : WRITE_MEM;
                end
            end
            WRITE_MEM: state_d = DONE;
            DONE: begin
                if (bus.cs_n) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase

        // Chip select released mid-frame: drop the transaction.
        if (bus.cs_n && (state_q != IDLE) && (state_q != DONE)) begin
            state_d = IDLE;
            abort_d = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    // Every state change restarts the count for the next phase.
    assign cnt_clr = (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rw_q          <= 1'b0;
            addr_we_q     <= 1'b0;
            dm_we_q       <= 1'b0;
            sr_we_q       <= 1'b0;
            miso_buf_en_q <= 1'b0;
            busy_q        <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            addr_we_q     <= (state_d == GOT);
            dm_we_q       <= (state_d == WRITE_MEM);
            sr_we_q       <= (state_d == LOAD);
            miso_buf_en_q <= (state_d == SEND);
            busy_q        <= (state_d != IDLE);
            abort_q       <= abort_d;
        end
    end

    assign bus.addr_we     = addr_we_q;
    assign bus.dm_we       = dm_we_q;
    assign bus.sr_we       = sr_we_q;
    assign bus.miso_buf_en = miso_buf_en_q;
    assign bus.busy        = busy_q;
    assign bus.abort       = abort_q;

endmodule
